// File: rtl/range_counter_updn_if.sv
// Bus interface for range_counter_updn: control, load data, count and status flags.
// The step field exists only when RANGE_CNT_STEP_EN is defined.
interface range_counter_updn_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic             up_dn;
    logic             mode;
    logic [WIDTH-1:0] data;
`ifdef RANGE_CNT_STEP_EN
    logic [WIDTH-1:0] step;
`endif
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_min;
    logic             wrap;

    modport master (
`ifdef RANGE_CNT_STEP_EN
        output step,
`endif
        output en, load, up_dn, mode, data,
        input  count, at_max, at_min, wrap
    );

    modport slave (
`ifdef RANGE_CNT_STEP_EN
        input  step,
`endif
        input  en, load, up_dn, mode, data,
        output count, at_max, at_min, wrap
    );
endinterface

// File: rtl/range_counter_updn.sv
// Up/down counter confined to [MIN,MAX] with wrap or saturate at the bounds.
// Define RANGE_CNT_STEP_EN to add a variable step input; otherwise the step is 1.
module range_counter_updn #(
    parameter int WIDTH = 8,
    parameter int MIN   = 10,
    parameter int MAX   = 40
) (
    input logic                 clk,
    input logic                 rst,
    range_counter_updn_if.slave bus
);
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    if (MIN >= MAX) begin : g_bad_range
        $error("range_counter_updn: MIN must be less than MAX");
    end
    if (longint'(MAX) > (longint'(1) << WIDTH) - 1) begin : g_bad_width
        $error("range_counter_updn: MAX does not fit in WIDTH bits");
    end

    logic [WIDTH-1:0] step_w;
`ifdef RANGE_CNT_STEP_EN
    assign step_w = bus.step;
`else
    assign step_w = WIDTH'(1);
`endif

    logic [WIDTH-1:0]        count_q;
    logic [WIDTH-1:0]        count_nxt;
    logic                    wrap_q;
    logic                    wrap_nxt;
    logic [WIDTH:0]          up_next;
    logic signed [WIDTH:0]   dn_next;

    // Extra bit keeps sums and differences exact, so bound checks never alias.
    assign up_next = {1'b0, count_q} + {1'b0, step_w};
    assign dn_next = $signed({1'b0, count_q}) - $signed({1'b0, step_w});

    always_comb begin
        count_nxt = count_q;
        wrap_nxt  = 1'b0;
        if (bus.load) begin
            if (bus.data < MIN_V)
                count_nxt = MIN_V;
            else if (bus.data > MAX_V)
                count_nxt = MAX_V;
            else
                count_nxt = bus.data;
        end else if (bus.en) begin
            if ((count_q < MIN_V) || (count_q > MAX_V)) begin
                count_nxt = MIN_V;
            end else if (bus.up_dn) begin
                if (up_next <= {1'b0, MAX_V}) begin
                    count_nxt = up_next[WIDTH-1:0];
                end else if (bus.mode) begin
                    count_nxt = MAX_V;
                end else begin
                    count_nxt = MIN_V;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                if (dn_next >= $signed({1'b0, MIN_V})) begin
                    count_nxt = dn_next[WIDTH-1:0];
                end else if (bus.mode) begin
                    count_nxt = MIN_V;
                end else begin
                    count_nxt = MAX_V;
                    wrap_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= MIN_V;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_nxt;
            wrap_q  <= wrap_nxt;
        end
    end

    assign bus.count  = count_q;
    assign bus.wrap   = wrap_q;
    assign bus.at_max = (count_q == MAX_V);
    assign bus.at_min = (count_q == MIN_V);
endmodule
